t09_sound_sequencer: RTL and testbench

//  Multi-channel successor to the single-tone sound generator: CH independent game events
//  (good/bad collision, button, ...) each trigger a tone of programmable pitch, duration and

---
 rtl/t09_sound_sequencer_if.sv | 27 ++
 rtl/t09_sound_sequencer.sv | 155 +++++++++++++++
 tb/tb_t09_sound_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/t09_sound_sequencer_if.sv
// Bus between the game logic and the sound sequencer.
// The game side drives the event and tone settings; the sequencer returns its status and the DAC sample.
interface t09_sound_sequencer_if #(
    parameter int N     = 8,
    parameter int CH    = 4,
    parameter int DIV_W = 16,
    parameter int DUR_W = 20
);
    logic [CH-1:0]       event_i;
    logic [CH*DIV_W-1:0] period_i;
    logic [CH*DUR_W-1:0] dur_i;
    logic [CH-1:0]       mode_i;
    logic                mute_i;
    logic                busy_o;
    logic [CH-1:0]       active_o;
    logic [N-1:0]        soundOut;

    modport master (
        output event_i, period_i, dur_i, mode_i, mute_i,
        input  busy_o, active_o, soundOut
    );

    modport slave (
        input  event_i, period_i, dur_i, mode_i, mute_i,
        output busy_o, active_o, soundOut
    );
endinterface

// File: rtl/t09_sound_sequencer.sv
// Multi-channel tone sequencer. Each channel has a rising-edge request latch.
// A fixed-priority arbiter with preemption picks one channel, and its square or sawtooth tone drives a registered DAC sample.
module t09_sound_sequencer #(
    parameter int N     = 8,
    parameter int CH    = 4,
    parameter int DIV_W = 16,
    parameter int DUR_W = 20,
    parameter int GAP   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    t09_sound_sequencer_if.slave   bus
);
    localparam int AW = (CH > 1) ? $clog2(CH) : 1;
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    state_t           state_q, state_d;
    logic [CH-1:0]    evt_q, pend_q, pend_d;
    logic [AW-1:0]    act_q, act_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             level_q, level_d;
    logic [N-1:0]     phase_q, phase_d;
    logic [N-1:0]     snd_q, snd_d;

    logic [DIV_W-1:0] period_arr [CH];
    logic [DUR_W-1:0] dur_arr [CH];
    logic [CH-1:0]    rise, clr;
    logic [AW-1:0]    sel;
    logic             any_pend, load, tick;
    logic [DIV_W-1:0] p_eff;
    logic [N-1:0]     sample;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            assign period_arr[gi]   = bus.period_i[gi*DIV_W +: DIV_W];
            assign dur_arr[gi]      = bus.dur_i[gi*DUR_W +: DUR_W];
            assign bus.active_o[gi] = (state_q == S_PLAY) && (act_q == AW'(gi));
        end
    endgenerate

    assign rise     = bus.event_i & ~evt_q;
    assign any_pend = |pend_q;

    // Scan from the top so the lowest pending index wins.
    always_comb begin
        sel = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (pend_q[i]) sel = AW'(i);
        end
    end

    // A period of zero behaves like one: a tick every cycle.
    assign p_eff  = (period_arr[act_q] == '0) ? DIV_W'(1) : period_arr[act_q];
    assign tick   = (div_q == p_eff - DIV_W'(1));
    assign sample = bus.mode_i[act_q] ? phase_q : {N{level_q}};

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        div_d   = div_q;
        dur_d   = dur_q;
        gap_d   = gap_q;
        level_d = level_q;
        phase_d = phase_q;
        clr     = '0;
        load    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (any_pend) begin
                    clr[sel] = 1'b1;
                    load     = (dur_arr[sel] != '0);
                end
            end
            S_PLAY: begin
                if (any_pend && (sel < act_q)) begin
                    clr[sel] = 1'b1;
                    load     = (dur_arr[sel] != '0);
                end
                if (!load) begin
                    div_d = tick ? '0 : div_q + DIV_W'(1);
                    if (tick) begin
                        level_d = ~level_q;
                        phase_d = phase_q + N'(1);
                    end
                    if (pend_q[act_q]) clr[act_q] = 1'b1;
                    // A retrigger restarts the length but keeps the waveform running.
                    if (pend_q[act_q] && (dur_arr[act_q] != '0)) begin
                        dur_d = dur_arr[act_q];
                    end else if (dur_q == DUR_W'(1)) begin
                        state_d = S_GAP;
                        gap_d   = GW'(GAP);
                    end else begin
                        dur_d = dur_q - DUR_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GW'(1)) begin
                    state_d = S_IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            state_d = S_PLAY;
            act_d   = sel;
            div_d   = '0;
            dur_d   = dur_arr[sel];
            level_d = 1'b0;
            phase_d = '0;
        end

        pend_d = (pend_q & ~clr) | rise;
        snd_d  = ((state_q == S_PLAY) && !bus.mute_i) ? sample : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            evt_q   <= '0;
            pend_q  <= '0;
            act_q   <= '0;
            div_q   <= '0;
            dur_q   <= '0;
            gap_q   <= '0;
            level_q <= 1'b0;
            phase_q <= '0;
            snd_q   <= '0;
        end else begin
            state_q <= state_d;
            evt_q   <= bus.event_i;
            pend_q  <= pend_d;
            act_q   <= act_d;
            div_q   <= div_d;
            dur_q   <= dur_d;
            gap_q   <= gap_d;
            level_q <= level_d;
            phase_q <= phase_d;
            snd_q   <= snd_d;
        end
    end

    assign bus.busy_o   = (state_q != S_IDLE);
    assign bus.soundOut = snd_q;
endmodule

// File: tb/tb_t09_sound_sequencer.sv
// Scoreboard bench for t09_sound_sequencer.
// Stimulus queues the expected per-cycle (busy, active, sample) tuples; the negedge monitor pops and compares them.
module tb_t09_sound_sequencer;
    localparam int N = 8, CH = 4, DIV_W = 16, DUR_W = 20, GAP = 16;

    typedef struct packed {
        logic       busy;
        logic [3:0] act;
        logic [7:0] snd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    t09_sound_sequencer_if #(.N(N), .CH(CH), .DIV_W(DIV_W), .DUR_W(DUR_W)) vif ();

    t09_sound_sequencer #(.N(N), .CH(CH), .DIV_W(DIV_W), .DUR_W(DUR_W), .GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total = total + 1;
            if ({vif.busy_o, vif.active_o, vif.soundOut} !== e) begin
                bad = bad + 1;
                $display("FAIL cyc%0d actual busy=%0b act=%b snd=%02h required busy=%0b act=%b snd=%02h",
                         cyc, vif.busy_o, vif.active_o, vif.soundOut, e.busy, e.act, e.snd);
            end
        end
    end

    function automatic logic [7:0] smp(int j, int p, bit m);
        int t;
        t = j / p;
        if (m) return 8'(t % 256);
        return ((t % 2) == 1) ? 8'hFF : 8'h00;
    endfunction

    task automatic push_idle(int n);
        for (int i = 0; i < n; i++) exp_q.push_back(exp_t'(13'h0));
    endtask

    task automatic push_play(int ch, int n, int p, bit m, bit mu, logic [7:0] first,
                             output logic [7:0] last);
        for (int j = 0; j < n; j++) begin
            exp_t e;
            e.busy = 1'b1;
            e.act  = 4'(1 << ch);
            e.snd  = (j == 0) ? first : (mu ? 8'h00 : smp(j - 1, p, m));
            exp_q.push_back(e);
        end
        last = mu ? 8'h00 : smp(n - 1, p, m);
    endtask

    task automatic push_gap(logic [7:0] first);
        for (int i = 0; i < GAP; i++) begin
            exp_t e;
            e.busy = 1'b1;
            e.act  = 4'b0000;
            e.snd  = (i == 0) ? first : 8'h00;
            exp_q.push_back(e);
        end
    endtask

    task automatic set_ch(int c, int p, int d, bit m);
        vif.period_i[c*DIV_W +: DIV_W] = DIV_W'(p);
        vif.dur_i[c*DUR_W +: DUR_W]    = DUR_W'(d);
        vif.mode_i[c]                  = m;
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            b++;
            if (b > 5000) begin
                $display("FAIL drain_timeout actual_left=%0d required=0", exp_q.size());
                $fatal(1, "scoreboard did not drain");
            end
        end
        step(1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] l1, l2;
        rst          = 1'b1;
        vif.event_i  = '0;
        vif.period_i = '0;
        vif.dur_i    = '0;
        vif.mode_i   = '0;
        vif.mute_i   = 1'b0;
        push_idle(2);
        step(1);
        rst = 1'b0;
        drain();

        // Square tone on ch1, period 4, 40 cycles, then the gap.
        set_ch(1, 4, 40, 0);
        vif.event_i = 4'b0010;
        push_idle(2);
        push_play(1, 40, 4, 0, 0, 8'h00, l1);
        push_gap(l1);
        push_idle(2);
        step(1);
        vif.event_i = '0;
        drain();

        // Sawtooth on ch2, period 1: 0..255 then wrap.
        set_ch(2, 1, 300, 1);
        vif.event_i = 4'b0100;
        push_idle(2);
        push_play(2, 300, 1, 1, 0, 8'h00, l1);
        push_gap(l1);
        push_idle(2);
        step(1);
        vif.event_i = '0;
        drain();

        // ch0 preempts ch3 after 20 play cycles; ch3 never resumes.
        set_ch(3, 2, 100, 0);
        set_ch(0, 3, 10, 0);
        vif.event_i = 4'b1000;
        push_idle(2);
        push_play(3, 20, 2, 0, 0, 8'h00, l1);
        push_play(0, 10, 3, 0, 0, l1, l2);
        push_gap(l2);
        push_idle(3);
        step(1);
        vif.event_i = '0;
        step(19);
        vif.event_i = 4'b0001;
        step(1);
        vif.event_i = '0;
        drain();

        // Simultaneous rises on ch1 and ch2: ch1, gap, one idle cycle, ch2.
        set_ch(1, 2, 12, 0);
        set_ch(2, 1, 8, 1);
        vif.event_i = 4'b0110;
        push_idle(2);
        push_play(1, 12, 2, 0, 0, 8'h00, l1);
        push_gap(l1);
        push_idle(1);
        push_play(2, 8, 1, 1, 0, 8'h00, l2);
        push_gap(l2);
        push_idle(2);
        step(1);
        vif.event_i = '0;
        drain();

        // Zero-length request is dropped.
        set_ch(0, 3, 0, 0);
        vif.event_i = 4'b0001;
        push_idle(6);
        step(1);
        vif.event_i = '0;
        drain();

        // Held level yields one tone only.
        set_ch(0, 3, 5, 0);
        vif.event_i = 4'b0001;
        push_idle(2);
        push_play(0, 5, 3, 0, 0, 8'h00, l1);
        push_gap(l1);
        push_idle(77);
        step(100);
        vif.event_i = '0;
        push_idle(3);
        drain();

        // Muted tone: silent samples, unchanged busy/active timing.
        vif.mute_i = 1'b1;
        set_ch(1, 4, 20, 0);
        vif.event_i = 4'b0010;
        push_idle(2);
        push_play(1, 20, 4, 0, 1, 8'h00, l1);
        push_gap(l1);
        push_idle(2);
        step(1);
        vif.event_i = '0;
        drain();
        vif.mute_i = 1'b0;

        // Reset mid-tone with ch3 queued: outputs clear before the next edge, nothing replays.
        set_ch(2, 2, 50, 0);
        set_ch(3, 5, 30, 0);
        vif.event_i = 4'b0100;
        push_idle(2);
        push_play(2, 10, 2, 0, 0, 8'h00, l1);
        step(1);
        vif.event_i = '0;
        step(1);
        vif.event_i = 4'b1000;
        step(1);
        vif.event_i = '0;
        step(9);
        push_idle(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        push_idle(6);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
